// File: rtl/char_lcd_ctrl.sv
// HD44780 controller: power-up wait, init sequence, then endless refresh from a host-writable shadow buffer.
// One LCD transfer per TICK_CYCLES; no backpressure. `define LCD_CURSOR_EN adds cursor position/blink commands per frame.
module char_lcd_ctrl #(
  parameter int POWERUP_CYCLES = 90000,
  parameter int TICK_CYCLES    = 100000,
  parameter int CLEAR_TICKS    = 2,
  parameter int COLS           = 16,
  parameter int ROWS           = 2,
  parameter int AW             = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
`ifdef LCD_CURSOR_EN
  input  logic          cursor_vis,
  input  logic [AW-1:0] cursor_addr,
`endif
  output logic          lcd_en,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_on,
  output logic [7:0]    lcd_data,
  output logic          init_done,
  output logic          frame_done
);

  localparam int NCHAR = ROWS * COLS;
  localparam int IW    = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int PW    = $clog2(POWERUP_CYCLES + 1);
  localparam int TW    = $clog2(TICK_CYCLES);
  localparam int WW    = $clog2(CLEAR_TICKS + 2);
  localparam int CW    = $clog2(COLS + 1);

  localparam logic [PW-1:0] PWR_LAST  = PW'(POWERUP_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICK_CYCLES / 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(CLEAR_TICKS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic          ROW_LAST  = 1'(ROWS - 1);
  localparam logic [7:0]    FUNC_BYTE = (ROWS == 2) ? 8'h38 : 8'h30;

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_FUNC,
    S_OFF,
    S_CLR,
    S_CLR_WAIT,
    S_ENTRY,
    S_ON,
    S_ROW_ADDR,
`ifdef LCD_CURSOR_EN
    S_CUR_ADDR,
    S_CUR_CTRL,
`endif
    S_CHAR
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pwr_cnt, pwr_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic          row, row_n;
  logic [CW-1:0] col, col_n;
  logic          rs_n, init_n;
  logic [7:0]    data_n;
  logic          tick;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_byte;
  logic [7:0]    char_buf [NCHAR];

  assign lcd_rw = 1'b0;
  assign lcd_on = 1'b1;
  assign tick   = (state != S_PWR_WAIT) && (tick_cnt == TICK_LAST);
  // E is suppressed while waiting for Clear to finish so the held 0x01 is not re-issued.
  assign lcd_en = (state != S_PWR_WAIT) && (state != S_CLR_WAIT) && (tick_cnt < TICK_HALF);

  // ROW_ADDR loads column 0 of the current row; CHAR loads the following column.
  assign rd_idx  = IW'((row ? COLS : 0) + ((state == S_CHAR) ? int'(col) + 1 : 0));
  assign rd_byte = char_buf[rd_idx];

`ifdef LCD_CURSOR_EN
  logic [7:0] cur_addr_byte;
  always_comb begin
    int ci;
    ci = (32'(cursor_addr) < NCHAR) ? int'(cursor_addr) : 0;
    if (ci >= COLS) cur_addr_byte = 8'h80 | (8'h40 + 8'(ci - COLS));
    else            cur_addr_byte = 8'h80 | 8'(ci);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCHAR; i++) char_buf[i] <= 8'h20;
    end else if (wr_en && (32'(wr_addr) < NCHAR)) begin
      char_buf[IW'(wr_addr)] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_PWR_WAIT;
      pwr_cnt   <= '0;
      tick_cnt  <= '0;
      wait_cnt  <= '0;
      row       <= 1'b0;
      col       <= '0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 8'h00;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      pwr_cnt   <= pwr_n;
      tick_cnt  <= tick_n;
      wait_cnt  <= wait_n;
      row       <= row_n;
      col       <= col_n;
      lcd_rs    <= rs_n;
      lcd_data  <= data_n;
      init_done <= init_n;
    end
  end

  always_comb begin
    state_n    = state;
    pwr_n      = pwr_cnt;
    tick_n     = tick_cnt;
    wait_n     = wait_cnt;
    row_n      = row;
    col_n      = col;
    rs_n       = lcd_rs;
    data_n     = lcd_data;
    init_n     = init_done;
    frame_done = 1'b0;

    if (state == S_PWR_WAIT) begin
      if (pwr_cnt == PWR_LAST) begin
        state_n = S_FUNC;
        rs_n    = 1'b0;
        data_n  = FUNC_BYTE;
        tick_n  = '0;
      end else begin
        pwr_n = pwr_cnt + PW'(1);
      end
    end else begin
      tick_n = tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        case (state)
          S_FUNC: begin
            state_n = S_OFF;
            data_n  = 8'h08;
          end
          S_OFF: begin
            state_n = S_CLR;
            data_n  = 8'h01;
          end
          S_CLR: begin
            if (CLEAR_TICKS > 0) begin
              state_n = S_CLR_WAIT;
              wait_n  = '0;
            end else begin
              state_n = S_ENTRY;
              data_n  = 8'h06;
            end
          end
          S_CLR_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              state_n = S_ENTRY;
              data_n  = 8'h06;
            end else begin
              wait_n = wait_cnt + WW'(1);
            end
          end
          S_ENTRY: begin
            state_n = S_ON;
            data_n  = 8'h0C;
          end
          S_ON: begin
            state_n = S_ROW_ADDR;
            row_n   = 1'b0;
            rs_n    = 1'b0;
            data_n  = 8'h80;
            init_n  = 1'b1;
          end
          S_ROW_ADDR: begin
            state_n = S_CHAR;
            col_n   = '0;
            rs_n    = 1'b1;
            data_n  = rd_byte;
          end
          S_CHAR: begin
            if (col != COL_LAST) begin
              col_n  = col + CW'(1);
              data_n = rd_byte;
            end else if (row != ROW_LAST) begin
              state_n = S_ROW_ADDR;
              row_n   = 1'b1;
              rs_n    = 1'b0;
              data_n  = 8'hC0;
            end else begin
`ifdef LCD_CURSOR_EN
              state_n = S_CUR_ADDR;
              rs_n    = 1'b0;
              data_n  = cur_addr_byte;
`else
              frame_done = 1'b1;
              state_n    = S_ROW_ADDR;
              row_n      = 1'b0;
              rs_n       = 1'b0;
              data_n     = 8'h80;
`endif
            end
          end
`ifdef LCD_CURSOR_EN
          S_CUR_ADDR: begin
            state_n = S_CUR_CTRL;
            data_n  = cursor_vis ? 8'h0F : 8'h0C;
          end
          S_CUR_CTRL: begin
            frame_done = 1'b1;
            state_n    = S_ROW_ADDR;
            row_n      = 1'b0;
            data_n     = 8'h80;
          end
`endif
          default: state_n = S_PWR_WAIT;
        endcase
      end
    end
  end

endmodule
